// File: rtl/rr_arbiter8_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
// Shared constants for the eight-requester round-robin arbiter: requester
// count, index width, FSM state encodings and a one-hot helper.
// Optional feature macro used by the arbiter: ARB_TIMEOUT_EN.
// ----------------------------------------------------------------------------
package arb_pkg;

    localparam int ARB_N  = 8;
    localparam int ARB_IW = 3;

    typedef logic [0:0] arb_state_t;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    function automatic logic [ARB_N-1:0] arb_onehot(input logic [ARB_IW-1:0] idx);
        logic [ARB_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// ----------------------------------------------------------------------------
// rr_arbiter8_if
// Request/grant bundle between the requesters and the arbiter.
//   sel       master->slave  arbitration enable
//   req[7:0]  master->slave  level request vector
//   gnt[7:0]  slave->master  registered one-hot grant
//   gnt_id    slave->master  binary index of the owner (0 when no owner)
//   gnt_vld   slave->master  1 when gnt is non-zero
//   dbg_state slave->master  arbiter FSM state (IDLE/BUSY)
//
// Handshake: req[i] is a level that the requester holds until it sees
// gnt[i]; it keeps holding req[i] for as long as it wants the resource and
// drops it to release. gnt is registered, so a request sampled at edge n is
// answered after edge n; there is no separate ready, and a request dropped
// before it is granted is simply forgotten.
// ----------------------------------------------------------------------------
interface rr_arbiter8_if;
    import arb_pkg::*;

    logic              sel;
    logic [ARB_N-1:0]  req;
    logic [ARB_N-1:0]  gnt;
    logic [ARB_IW-1:0] gnt_id;
    logic              gnt_vld;
    arb_state_t        dbg_state;

    modport master (
        output sel, req,
        input  gnt, gnt_id, gnt_vld, dbg_state
    );

    modport slave (
        input  sel, req,
        output gnt, gnt_id, gnt_vld, dbg_state
    );

endinterface

// File: rtl/rr_arbiter8_pick.sv
// ----------------------------------------------------------------------------
// rr_pick8
// Combinational rotated priority encoder. Returns the first set bit of req
// searching ptr, ptr+1, ... ptr+7 (mod 8).
//   req[7:0]  in   candidate requests
//   ptr[2:0]  in   highest-priority index
//   pick[2:0] out  selected index (0 when any=0)
//   any       out  1 when req is non-zero
// ----------------------------------------------------------------------------
module rr_pick8
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]  req,
    input  logic [ARB_IW-1:0] ptr,
    output logic [ARB_IW-1:0] pick,
    output logic              any
);

    logic [2*ARB_N-1:0] w_dbl;
    logic [ARB_N-1:0]   w_rot;
    logic [ARB_IW-1:0]  w_off;

    // w_rot[j] = req[(ptr + j) mod 8]: doubling the vector makes the
    // rotation a plain indexed slice.
    assign w_dbl = {req, req};
    assign w_rot = w_dbl[ptr +: ARB_N];

    // Scan from the top down so the lowest set offset wins.
    always_comb begin
        w_off = '0;
        for (int j = ARB_N - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = ARB_IW'(j);
            end
        end
    end

    assign pick = ptr + w_off;
    assign any  = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// ----------------------------------------------------------------------------
// rr_arbiter8
// Eight-requester round-robin arbiter with a registered one-hot grant.
// The owner keeps the grant while it requests; on release the next
// requester (searching from one past the last owner) is granted at the same
// edge. sel=0 withdraws the grant without moving the priority pointer.
//
// Parameters:
//   HOLD_MAX  max consecutive grant cycles while others wait (timeout only)
//   CNT_W     hold-counter width, 2**CNT_W >= HOLD_MAX
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   io_arb    rr_arbiter8_if.slave (sel, req in; gnt, gnt_id, gnt_vld,
//             dbg_state out)
// Configuration macro:
//   ARB_TIMEOUT_EN  preempt an owner after HOLD_MAX cycles when others wait
// ----------------------------------------------------------------------------
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter8_if.slave   io_arb
);

    if (HOLD_MAX < 2 || HOLD_MAX > 256 || (2 ** CNT_W) < HOLD_MAX) begin : g_cfg_check
        $error("rr_arbiter8: HOLD_MAX must be 2..256 and fit in CNT_W bits");
    end

    arb_state_t        r_state;
    logic [ARB_IW-1:0] r_ptr;
    logic [ARB_IW-1:0] r_own;
    logic [ARB_N-1:0]  r_gnt;

    arb_state_t        w_nxt_state;
    logic [ARB_IW-1:0] w_nxt_ptr;
    logic [ARB_IW-1:0] w_nxt_own;
    logic [ARB_N-1:0]  w_nxt_gnt;

    logic [ARB_N-1:0]  w_cand;
    logic [ARB_IW-1:0] w_pick;
    logic              w_any;
    logic              w_own_req;
    logic              w_do_grant;
    logic              w_go_idle;

    // The current owner is never a candidate: on release its bit is already
    // low, and on preemption it must not re-win.
    assign w_cand    = io_arb.req & ~r_gnt;
    assign w_own_req = io_arb.req[r_own];

    rr_pick8 u_pick (
        .req  (w_cand),
        .ptr  (r_ptr),
        .pick (w_pick),
        .any  (w_any)
    );

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] w_nxt_hcnt;
    logic             w_hold_expired;

    // ">=" rather than "==": if the owner ran alone past the limit and the
    // counter kept counting, a newcomer must still be able to preempt it.
    assign w_hold_expired = (r_hcnt >= CNT_W'(HOLD_MAX - 1));
`endif

    always_comb begin
        w_do_grant = 1'b0;
        w_go_idle  = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                w_do_grant = io_arb.sel && w_any;
            end
            ARB_BUSY: begin
                if (!io_arb.sel) begin
                    w_go_idle = 1'b1;
                end else if (!w_own_req) begin
                    if (w_any) begin
                        w_do_grant = 1'b1;
                    end else begin
                        w_go_idle = 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (w_hold_expired && w_any) begin
                    w_do_grant = 1'b1;
                end
`endif
            end
            default: begin
                w_go_idle = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_own   = r_own;
        w_nxt_gnt   = r_gnt;
        if (w_do_grant) begin
            w_nxt_state = ARB_BUSY;
            w_nxt_own   = w_pick;
            w_nxt_gnt   = arb_onehot(w_pick);
            // New owner drops to lowest priority for the following pick.
            w_nxt_ptr   = w_pick + ARB_IW'(1);
        end else if (w_go_idle) begin
            w_nxt_state = ARB_IDLE;
            w_nxt_own   = '0;
            w_nxt_gnt   = '0;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_comb begin
        w_nxt_hcnt = r_hcnt;
        if (w_do_grant || w_go_idle) begin
            w_nxt_hcnt = '0;
        end else if (r_state == ARB_BUSY && r_hcnt != '1) begin
            w_nxt_hcnt = r_hcnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt <= '0;
        end else begin
            r_hcnt <= w_nxt_hcnt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_own   <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_ptr   <= w_nxt_ptr;
            r_own   <= w_nxt_own;
            r_gnt   <= w_nxt_gnt;
        end
    end

    // r_own is cleared whenever the FSM leaves BUSY, so gnt_id reads 0 with
    // no owner and always matches gnt.
    assign io_arb.gnt       = r_gnt;
    assign io_arb.gnt_id    = r_own;
    assign io_arb.gnt_vld   = (r_state == ARB_BUSY);
    assign io_arb.dbg_state = r_state;

endmodule

// File: tb/tb_rr_arbiter8.sv
// ----------------------------------------------------------------------------
// tb_rr_arbiter8
// Directed, table-driven bench for rr_arbiter8. Each table row gives the
// inputs held for one clock and the grant expected after that edge.
// ----------------------------------------------------------------------------
module tb_rr_arbiter8;
    import arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_arbiter8_if arb ();

    rr_arbiter8 #(
        .HOLD_MAX (4),
        .CNT_W    (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_arb (arb)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic       v_rst;
        logic       v_sel;
        logic [7:0] v_req;
        logic       e_vld;
        logic [2:0] e_id;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic [7:0] q,
                                input logic vld, input logic [2:0] id);
        vec_t v;
        v.v_rst = r;
        v.v_sel = s;
        v.v_req = q;
        v.e_vld = vld;
        v.e_id  = id;
        vecs.push_back(v);
    endfunction

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];   // {vld, id[2:0], gnt[7:0]}
    int checks = 0;
    int errors = 0;

    task automatic expect_out(input logic vld, input logic [2:0] id);
        logic [7:0] g;
        g = vld ? (8'd1 << id) : 8'd0;
        exp_q.push_back({vld, (vld ? id : 3'd0), g});
    endtask

    task automatic check_out(input string name);
        logic [11:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (arb.gnt !== e[7:0]) begin
            errors++;
            $display("FAIL %s gnt: got %h want %h", name, arb.gnt, e[7:0]);
        end
        checks++;
        if (arb.gnt_id !== e[10:8]) begin
            errors++;
            $display("FAIL %s gnt_id: got %0d want %0d", name, arb.gnt_id, e[10:8]);
        end
        checks++;
        if (arb.gnt_vld !== e[11]) begin
            errors++;
            $display("FAIL %s gnt_vld: got %b want %b", name, arb.gnt_vld, e[11]);
        end
        checks++;
        if (arb.dbg_state !== (e[11] ? ARB_BUSY : ARB_IDLE)) begin
            errors++;
            $display("FAIL %s state: got %b want %b", name, arb.dbg_state, e[11]);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic r, input logic s, input logic [7:0] q);
        @(negedge clk);
        rst     = r;
        arb.sel = s;
        arb.req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic r, input logic s,
                        input logic [7:0] q, input logic vld, input logic [2:0] id);
        expect_out(vld, id);
        drive_cycle(r, s, q);
        check_out(name);
    endtask

    // ---------------- test ----------------
    initial begin
        rst     = 1'b1;
        arb.sel = 1'b0;
        arb.req = 8'h00;

        // Reset, and reset overriding sel/req; sel=0 blocks requests.
        add(1, 0, 8'h00, 0, 0);
        add(1, 1, 8'hFF, 0, 0);
        add(0, 0, 8'hFF, 0, 0);
        add(0, 1, 8'h00, 0, 0);

        // Single requesters 0..7, three cycles each; handover is gapless.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 3; k++) begin
                add(0, 1, 8'(1 << i), 1, 3'(i));
            end
        end
        add(0, 1, 8'h00, 0, 0);          // ptr wrapped to 0

        // All request; each owner drops after two grant cycles.
        add(0, 1, 8'hFF, 1, 0);
        add(0, 1, 8'hFF, 1, 0);
        for (int k = 1; k < 8; k++) begin
            add(0, 1, 8'hFF & ~8'(1 << (k - 1)), 1, 3'(k));
            add(0, 1, 8'hFF, 1, 3'(k));
        end
        add(0, 1, 8'h7F, 1, 0);
        add(0, 1, 8'hFF, 1, 0);
        add(0, 1, 8'h00, 0, 0);          // ptr = 1

        // sel withdraw keeps ptr; resume picks from ptr=4.
        add(0, 1, 8'h08, 1, 3);
        add(0, 1, 8'h08, 1, 3);
        add(0, 0, 8'h08, 0, 0);
        add(0, 1, 8'h18, 1, 4);
        add(0, 1, 8'h20, 1, 5);
        // Mid-grant reset, then ptr back at 0.
        add(1, 1, 8'h20, 0, 0);
        add(0, 1, 8'h21, 1, 0);
        // Wrap 7 -> 0 with 0 and 7 competing.
        add(0, 1, 8'h81, 1, 0);
        add(0, 1, 8'h80, 1, 7);
        add(0, 1, 8'h81, 1, 7);
        add(0, 1, 8'h01, 1, 0);
        add(0, 1, 8'h00, 0, 0);

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].v_rst, vecs[i].v_sel, vecs[i].v_req,
                 vecs[i].e_vld, vecs[i].e_id);
        end

`ifdef ARB_TIMEOUT_EN
        // HOLD_MAX=4: owners 0 and 1 alternate every four cycles.
        step("tmo_rst", 1, 0, 8'h00, 0, 0);
        for (int c = 0; c < 40; c++) begin
            step($sformatf("tmo_alt%0d", c), 0, 1, 8'h03, 1, 3'((c / 4) % 2));
        end
        // A lone owner is never preempted.
        step("tmo_rst2", 1, 0, 8'h00, 0, 0);
        for (int c = 0; c < 20; c++) begin
            step($sformatf("tmo_solo%0d", c), 0, 1, 8'h01, 1, 0);
        end
`else
        // No preemption: owner 0 holds indefinitely against index 1.
        step("hold_rst", 1, 0, 8'h00, 0, 0);
        for (int c = 0; c < 120; c++) begin
            step($sformatf("hold_long%0d", c), 0, 1, 8'h03, 1, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-requester round-robin arbiter that shares one downstream resource (bus, encoder output path, shared register port) between requesters `req[0]`…`req[7]`. It registers a one-hot grant plus its 3-bit binary index, holds the grant while the owner keeps requesting, and rotates priority fairly. A global enable `sel` gates all arbitration, matching the enable convention of the 8-to-3 encoder.

## Interface
- `HOLD_MAX`, 16: maximum consecutive grant cycles for one owner while others wait; used only with `ARB_TIMEOUT_EN`; legal range 2..256.
- `CNT_W`, 8: hold-counter width; must satisfy 2^`CNT_W` ≥ `HOLD_MAX`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `sel`  in  1  arbitration enable; 0 withdraws any grant and blocks new ones.
- `req`  in  8  request vector; `req[i]` is level-sensitive and held until served.
- `gnt`  out  8  registered one-hot grant; all-zero when no owner.
- `gnt_id`  out  3  binary index of the owner; 0 when `gnt_vld`=0.
- `gnt_vld`  out  1  1 when `gnt` is non-zero.

## Operation
- States: IDLE (no owner), BUSY (one owner). Stored: `ptr[2:0]` (highest-priority index for the next pick), `own[2:0]`, `hcnt[CNT_W-1:0]`.
- Pick function: first set bit of `req` searching `ptr`, `ptr+1`, …, `ptr+7` (mod 8).
- IDLE, `sel`=1, `req`≠0: next edge → BUSY, `own`=pick, `gnt`=1<<pick, `hcnt`=0, `ptr`=pick+1 (mod 8, 7 wraps to 0).
- IDLE, `sel`=0 or `req`=0: stay IDLE, outputs 0.
- BUSY, `sel`=1, `req[own]`=1: hold grant; `hcnt` increments (saturates at all-ones).
- BUSY, `req[own]`=0: release. If other requests are present, the next pick is granted at the same edge (no dead cycle), with `ptr` updated from the new pick. Otherwise → IDLE.
- BUSY, `sel`=0: → IDLE at the next edge; `gnt`=0. `ptr` is unchanged, so fairness is kept.
- The `ptr` search is made after it advanced past the last owner. The departing owner therefore has the lowest priority in the following pick.
- Outputs come directly from registers. `gnt_id`/`gnt_vld` are consistent with `gnt` in every cycle.

## Timing
- Reset (`rst`=1 at an edge): state IDLE, `ptr`=0, `own`=0, `hcnt`=0, `gnt`=8'h00, `gnt_id`=0, `gnt_vld`=0. Reset overrides `sel`/`req` and may be applied mid-grant: the grant drops at that edge.
- Latency: `req` sampled at edge n appears as `gnt` after edge n (one cycle).
- Release latency: `req[own]` low at edge n → `gnt[own]` low after edge n. The successor grant appears in the same cycle.
- Simultaneous requests: resolved only by `ptr`. Example: `ptr`=0 and `req`=8'h81 grants index 0; the next pick with both still set grants index 7.
- A request that drops before it is granted is simply missed. No request is latched.

## Configuration
- `ARB_TIMEOUT_EN` defined: in BUSY, when `hcnt`=`HOLD_MAX`-1 and `req & ~gnt`≠0, the owner is preempted at the next edge. The next pick is granted and `hcnt` is cleared. If no other requester is waiting, the owner keeps the grant and `hcnt` saturates.
- `ARB_TIMEOUT_EN` undefined: there is no preemption. An owner holds the grant for as long as `req[own]` and `sel` stay 1. `hcnt` logic is removed.

## Structure
- Shared package `arb_pkg`: state encodings `ARB_IDLE`=1'b0 and `ARB_BUSY`=1'b1, plus the requester count constant `ARB_N`=8 and index width `ARB_IW`=3.
- One sub-module, `rr_pick8`: combinational rotated priority encoder with inputs `req[7:0]` and `ptr[2:0]`, and outputs `pick[2:0]` and `any`. The top holds the FSM, `ptr`, `hcnt` and the output registers.

## Test plan
- Reset then `sel`=1 with single requests `req`=8'h01, 8'h02, …, 8'h80, each held for 3 cycles → `gnt_id` = 0..7, one cycle after each `req`, each with `gnt_vld`=1.
- `req`=8'hFF held, with each owner dropping its request after 2 cycles of grant (then re-raising it) → grant order 0,1,2,…,7,0 with no idle cycle between grants.
- BUSY with `gnt_id`=3, then `sel`=0 → `gnt`=8'h00 at the next edge. Restore `sel`=1 with `req`=8'h18 → `gnt_id`=4 (`ptr`=4).
- `rst` asserted while `gnt`=8'h20 → `gnt`=8'h00, `gnt_id`=0, `gnt_vld`=0 after that edge. Afterwards, `req`=8'h21 → `gnt_id`=0.
- With `ARB_TIMEOUT_EN` and `HOLD_MAX`=4, `req`=8'h03 held → index 0 holds 4 cycles, then index 1 holds 4 cycles, alternating. With `req`=8'h01 alone, index 0 holds indefinitely.
- Without `ARB_TIMEOUT_EN`, the same `req`=8'h03 stimulus → index 0 holds the grant for 100+ cycles.
